// File: rtl/tdc_axil_slave.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tdc_axil_slave: AXI4-Lite slave holding four 32-bit TDC control regs.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tdc_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out,
   output logic [3:0]                        wr_pulse
);

   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      W_IDLE    = 3'd0,
      W_HAVE_AW = 3'd1,
      W_HAVE_W  = 3'd2,
      W_COMMIT  = 3'd3,
      W_RESP    = 3'd4
   } wstate_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_t;

   wstate_t wstate, wstate_nx;
   rstate_t rstate, rstate_nx;

   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
   logic [1:0]                    widx;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]             wstrb_q;
   logic                          aw_hs, w_hs, ar_hs;

   logic unused;
   assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   assign S_AXI_BRESP = 2'b00;
   assign S_AXI_RRESP = 2'b00;

   assign reg0_out = regs[0];
   assign reg1_out = regs[1];
   assign reg2_out = regs[2];
   assign reg3_out = regs[3];

   always_comb begin
      wstate_nx     = wstate;
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      wr_pulse      = 4'b0000;
      case (wstate)
         W_IDLE: begin
            S_AXI_AWREADY = 1'b1;
            S_AXI_WREADY  = 1'b1;
            if (S_AXI_AWVALID && S_AXI_WVALID) wstate_nx = W_COMMIT;
            else if (S_AXI_AWVALID)            wstate_nx = W_HAVE_AW;
            else if (S_AXI_WVALID)             wstate_nx = W_HAVE_W;
         end
         W_HAVE_AW: begin
            S_AXI_WREADY = 1'b1;
            if (S_AXI_WVALID) wstate_nx = W_COMMIT;
         end
         W_HAVE_W: begin
            S_AXI_AWREADY = 1'b1;
            if (S_AXI_AWVALID) wstate_nx = W_COMMIT;
         end
         W_COMMIT: begin
            wr_pulse[widx] = 1'b1;
            wstate_nx      = W_RESP;
         end
         W_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) wstate_nx = W_IDLE;
         end
         default: wstate_nx = W_IDLE;
      endcase
      // Keep the bus from accepting anything while reset is held.
      if (ARESET) begin
         S_AXI_AWREADY = 1'b0;
         S_AXI_WREADY  = 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wstate  <= W_IDLE;
         widx    <= 2'd0;
         wdata_q <= '0;
         wstrb_q <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         wstate <= wstate_nx;
         if (aw_hs) widx <= S_AXI_AWADDR[3:2];
         if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
         end
         if (wstate == W_COMMIT) begin
            for (int k = 0; k < STRB_W; k++) begin
               if (wstrb_q[k]) regs[widx][8*k +: 8] <= wdata_q[8*k +: 8];
            end
         end
      end
   end

   always_comb begin
      rstate_nx     = rstate;
      S_AXI_ARREADY = 1'b0;
      S_AXI_RVALID  = 1'b0;
      case (rstate)
         R_IDLE: begin
            S_AXI_ARREADY = ~ARESET;
            if (S_AXI_ARVALID && !ARESET) rstate_nx = R_DATA;
         end
         R_DATA: begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY) rstate_nx = R_IDLE;
         end
         default: rstate_nx = R_IDLE;
      endcase
   end

   // Sampling regs here with a commit on the same edge yields the pre-write value.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rstate      <= R_IDLE;
         S_AXI_RDATA <= '0;
      end else begin
         rstate <= rstate_nx;
         if (ar_hs) S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tdc_axil_slave.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_tdc_axil_slave: vector table, corner sequences and random traffic.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_tdc_axil_slave;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
   logic [3:0]  wr_pulse;

   int total = 0;
   int bad   = 0;
   logic [31:0] mdl [4];

   always #5 ACLK = ~ACLK;

   tdc_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out), .reg3_out(reg3_out),
      .wr_pulse(wr_pulse)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] reg_of(input int i);
      case (i)
         0:       return reg0_out;
         1:       return reg1_out;
         2:       return reg2_out;
         default: return reg3_out;
      endcase
   endfunction

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Full write; returns wr_pulse seen in the cycle after the last address/data handshake.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [3:0] pulse);
      bit aw_done, w_done, aw_now, w_now, held;
      int cyc, lat, idx;
      logic [31:0] mask;
      aw_done = 0; w_done = 0; cyc = 0; idx = int'(addr[3:2]);
      while (!(aw_done && w_done) && cyc < 100) begin
         S_AXI_AWADDR  = addr;
         S_AXI_WDATA   = data;
         S_AXI_WSTRB   = strb;
         S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
         S_AXI_WVALID  = !w_done && (cyc >= w_dly);
         aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
         w_now  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         aw_done |= aw_now;
         w_done  |= w_now;
         cyc++;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      chk("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
      pulse = wr_pulse;
      chk("wr_no_early_update", reg_of(idx), mdl[idx]);
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      mdl[idx] = (mdl[idx] & ~mask) | (data & mask);
      lat = 1;
      while (!S_AXI_BVALID && lat < 50) begin
         tick();
         lat++;
      end
      chk("b_latency", lat, 2);
      chk("wr_pulse_one_cycle", {28'd0, wr_pulse}, 32'd0);
      chk("reg_update", reg_of(idx), mdl[idx]);
      held = 1;
      for (int i = 0; i < b_dly; i++) begin
         if (!S_AXI_BVALID || S_AXI_AWREADY || S_AXI_WREADY) held = 0;
         tick();
      end
      chk("b_hold", {31'd0, held}, 32'd1);
      chk("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      chk("b_done", {31'd0, S_AXI_BVALID}, 32'd0);
   endtask

   task automatic axi_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data);
      int n;
      bit held;
      logic [31:0] first;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      n = 0;
      while (!S_AXI_ARREADY && n < 50) begin
         tick();
         n++;
      end
      chk("ar_ready", {31'd0, S_AXI_ARREADY}, 32'd1);
      tick();
      S_AXI_ARVALID = 1'b0;
      chk("r_latency", {31'd0, S_AXI_RVALID}, 32'd1);
      chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
      first = S_AXI_RDATA;
      held  = 1;
      for (int i = 0; i < r_dly; i++) begin
         tick();
         if (!S_AXI_RVALID || S_AXI_RDATA !== first || S_AXI_ARREADY) held = 0;
      end
      chk("r_hold", {31'd0, held}, 32'd1);
      data = S_AXI_RDATA;
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0;
      chk("r_done", {31'd0, S_AXI_RVALID}, 32'd0);
   endtask

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      logic [31:0] exp_rd;
      logic [3:0]  exp_pulse;
   } vec_t;

   vec_t vt [11];

   initial begin
      logic [31:0] rd;
      logic [3:0]  pls;
      bit          ok;

      vt[0]  = '{4'h0, 32'h0000_0001, 4'hF, 0, 0, 0, 32'h0000_0001, 4'b0001};
      vt[1]  = '{4'h4, 32'h0000_0002, 4'hF, 0, 0, 1, 32'h0000_0002, 4'b0010};
      vt[2]  = '{4'h8, 32'h0000_0003, 4'hF, 0, 0, 0, 32'h0000_0003, 4'b0100};
      vt[3]  = '{4'hC, 32'h0000_0004, 4'hF, 0, 0, 2, 32'h0000_0004, 4'b1000};
      vt[4]  = '{4'h5, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 32'hFFFF_FFFF, 4'b0010};
      vt[5]  = '{4'h4, 32'h1234_5678, 4'h5, 0, 0, 0, 32'hFF34_FF78, 4'b0010};
      vt[6]  = '{4'h0, 32'hAABB_CCDD, 4'h0, 0, 0, 0, 32'h0000_0001, 4'b0001};
      vt[7]  = '{4'h8, 32'hDEAD_BEEF, 4'hF, 0, 3, 0, 32'hDEAD_BEEF, 4'b0100};
      vt[8]  = '{4'h2, 32'h1122_3344, 4'h8, 3, 0, 1, 32'h1100_0001, 4'b0001};
      vt[9]  = '{4'h8, 32'h0BAD_F00D, 4'hF, 0, 2, 0, 32'h0BAD_F00D, 4'b0100};
      vt[10] = '{4'h8, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, 32'hDEAD_BEEF, 4'b0100};

      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = '0;

      // Reset state
      tick(); tick();
      chk("rst_ctrl", {24'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                       wr_pulse}, 32'd0);
      chk("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
      chk("rst_rdata", S_AXI_RDATA, 32'd0);
      chk("rst_regs", reg0_out | reg1_out | reg2_out | reg3_out, 32'd0);
      ARESET = 1'b0;
      #1;
      chk("ready_after_rst", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
      tick();

      // Vector table: write, then read back the same address
      for (int i = 0; i < 11; i++) begin
         axi_write(vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].aw_dly, vt[i].w_dly, vt[i].b_dly, pls);
         chk($sformatf("vec%0d_pulse", i), {28'd0, pls}, {28'd0, vt[i].exp_pulse});
         axi_read(vt[i].addr, i % 3, rd);
         chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i * 4), 0, rd);
         chk($sformatf("readback%0d", i), rd, mdl[i]);
      end

      // Response held off for 10 cycles while a read completes
      S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h0000_00A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      tick();
      mdl[0] = 32'h0000_00A5;
      ok = 1;
      for (int i = 0; i < 10; i++) begin
         if (!S_AXI_BVALID || S_AXI_AWREADY) ok = 0;
         if (i == 3) begin
            axi_read(4'h0, 0, rd);
            chk("stall_read", rd, 32'h0000_00A5);
         end
         tick();
      end
      chk("stall_bvalid_held", {31'd0, ok}, 32'd1);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      chk("stall_b_done", {31'd0, S_AXI_BVALID}, 32'd0);

      // AR handshake in the same cycle as the commit to index 3
      S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      chk("coincide_pulse", {28'd0, wr_pulse}, 32'd8);
      S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_ARVALID = 1'b0;
      chk("coincide_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
      chk("coincide_old", S_AXI_RDATA, 32'h4);
      S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      mdl[3] = 32'h99;
      axi_read(4'hC, 0, rd);
      chk("coincide_new", rd, 32'h99);

      // Reset while the address is held waiting for data
      S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      chk("have_aw_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd1);
      ARESET = 1'b1;
      S_AXI_WDATA = 32'h5555_5555; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      chk("midrst_ctrl", {24'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                          wr_pulse}, 32'd0);
      chk("midrst_regs", reg0_out | reg1_out | reg2_out | reg3_out | S_AXI_RDATA, 32'd0);
      S_AXI_WVALID = 1'b0;
      ARESET = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      ok = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (S_AXI_BVALID || wr_pulse != 4'b0) ok = 0;
      end
      chk("midrst_no_resp", {31'd0, ok}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i * 4), 0, rd);
         chk($sformatf("midrst_rd%0d", i), rd, 32'd0);
      end

      // Random traffic against the register model
      for (int n = 0; n < 40; n++) begin
         logic [3:0]  a, ra;
         logic [31:0] d;
         logic [3:0]  s;
         a  = 4'($urandom_range(0, 15));
         ra = 4'($urandom_range(0, 15));
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), pls);
         chk("rnd_pulse", {28'd0, pls}, 32'd1 << a[3:2]);
         axi_read(ra, $urandom_range(0, 2), rd);
         chk("rnd_rd", rd, mdl[ra[3:2]]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
